// File: rtl/mic_capture_controller.sv
// Captures a selectable channel subset of a stereo I2S word stream for a fixed number of frames.
// Output path is a 2-entry FIFO; words that find it full and not popping are dropped and counted.
module mic_capture_controller #(
  parameter int FRAMES_W = 16,
  parameter int DROP_W   = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic                abort_in,
  input  logic [FRAMES_W-1:0] num_frames_in,
  input  logic [1:0]          chan_sel_in,
  input  logic                s_axis_tvalid,
  input  logic [31:0]         s_axis_tdata,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic                m_axis_tvalid,
  output logic [31:0]         m_axis_tdata,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                busy_out,
  output logic                done_out,
  output logic                overflow_out,
  output logic [DROP_W-1:0]   drop_count_out
);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_CAPTURE, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [FRAMES_W-1:0] frames_q, frames_d;
  logic [1:0]          chan_q, chan_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic [31:0] data_q [2];
  logic        last_q [2];
  logic        rd_q, wr_q;
  logic [1:0]  cnt_q;

  logic pop, sel, final_frame, word_last, can_push, push, drop, flush;

  assign s_axis_tready  = 1'b1;
  assign m_axis_tvalid  = (cnt_q != 2'd0);
  assign m_axis_tdata   = data_q[rd_q];
  assign m_axis_tlast   = last_q[rd_q];
  assign busy_out       = (state_q != S_IDLE);
  assign done_out       = done_q;
  assign overflow_out   = ovf_q;
  assign drop_count_out = drop_q;

  assign pop         = m_axis_tvalid && m_axis_tready;
  assign sel         = (state_q == S_CAPTURE) && !abort_in && s_axis_tvalid &&
                       (s_axis_tlast ? chan_q[1] : chan_q[0]);
  assign final_frame = (frames_q == FRAMES_W'(1));
  // Final selected word: the right word when right is enabled, else the left word.
  assign word_last   = final_frame && (s_axis_tlast || !chan_q[1]);
  assign can_push    = (cnt_q != 2'd2) || pop;
  assign push        = sel && can_push;
  assign drop        = sel && !can_push;

  always_comb begin
    state_d  = state_q;
    frames_d = frames_q;
    chan_d   = chan_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    flush    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_in && (num_frames_in != '0) && (chan_sel_in != 2'b00)) begin
          state_d  = S_ALIGN;
          frames_d = num_frames_in;
          chan_d   = chan_sel_in;
          ovf_d    = 1'b0;
          drop_d   = '0;
        end
      end
      S_ALIGN: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          frames_d = frames_q - FRAMES_W'(1);
          if (final_frame) state_d = S_DRAIN;
        end
        if (drop) begin
          ovf_d = 1'b1;
          if (drop_q != {DROP_W{1'b1}}) drop_d = drop_q + DROP_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == 2'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_in && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      flush   = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      frames_q <= '0;
      chan_q   <= 2'b00;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      frames_q <= frames_d;
      chan_q   <= chan_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= 2'd0;
    end else if (flush) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_q] <= s_axis_tdata;
        last_q[wr_q] <= word_last;
        wr_q         <= ~wr_q;
      end
      // Full FIFO: the youngest entry sits just behind the write pointer, never at the head.
      if (drop && word_last) last_q[~wr_q] <= 1'b1;
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mic_capture_controller.sv
// Directed bench for mic_capture_controller: stereo, left-only, overflow, abort, invalid start, async reset.
module tb_mic_capture_controller;
  localparam int FW = 16;
  localparam int DW = 16;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic          abort_in = 1'b0;
  logic [FW-1:0] num_frames_in = '0;
  logic [1:0]    chan_sel_in = 2'b00;
  logic          s_axis_tvalid = 1'b0;
  logic [31:0]   s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic          busy_out;
  logic          done_out;
  logic          overflow_out;
  logic [DW-1:0] drop_count_out;

  mic_capture_controller #(.FRAMES_W(FW), .DROP_W(DW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .abort_in(abort_in),
    .num_frames_in(num_frames_in), .chan_sel_in(chan_sel_in),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .busy_out(busy_out), .done_out(done_out), .overflow_out(overflow_out),
    .drop_count_out(drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  logic [32:0] got_q[$];
  int done_cnt = 0;

  // Transfers complete on the next rising edge; outputs are stable at the falling edge before it.
  always @(negedge clk_in) begin
    if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
    if (done_out) done_cnt++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send(input logic last, input logic [31:0] d);
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = last;
    cyc();
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
  endtask

  task automatic do_start(input logic [FW-1:0] n, input logic [1:0] c);
    start_in = 1'b1; num_frames_in = n; chan_sel_in = c;
    cyc();
    start_in = 1'b0; num_frames_in = '0; chan_sel_in = 2'b00;
  endtask

  task automatic test_reset();
    cyc(2);
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_out); end
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); end
    total++; if (m_axis_tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata got=%h want=0", m_axis_tdata); end
    total++; if (overflow_out !== 1'b0 || drop_count_out !== '0) begin bad++; $display("FAIL reset_ovf got=%b/%0d want=0/0", overflow_out, drop_count_out); end
    total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL s_tready got=%b want=1", s_axis_tready); end
    rst_in = 1'b0;
    cyc();
  endtask

  task automatic test_stereo();
    logic [32:0] exp_w [4];
    logic [32:0] act;
    exp_w[0] = {1'b0, 32'hA}; exp_w[1] = {1'b0, 32'hB};
    exp_w[2] = {1'b0, 32'hC}; exp_w[3] = {1'b1, 32'hD};
    got_q.delete(); done_cnt = 0; m_axis_tready = 1'b1;
    do_start(2, 2'b11);
    total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL stereo_busy got=%b want=1", busy_out); end
    send(1'b0, 32'h1); send(1'b1, 32'h2);
    send(1'b0, 32'hA); send(1'b1, 32'hB); send(1'b0, 32'hC); send(1'b1, 32'hD);
    cyc(6);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL stereo_count got=%0d want=4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      act = (i < got_q.size()) ? got_q[i] : 33'bx;
      total++; if (act !== exp_w[i]) begin bad++; $display("FAIL stereo_word%0d got=%h want=%h", i, act, exp_w[i]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL stereo_done got=%0d want=1", done_cnt); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL stereo_idle got=%b want=0", busy_out); end
  endtask

  task automatic test_left_only();
    logic [32:0] exp_w [3];
    logic [32:0] act;
    exp_w[0] = {1'b0, 32'h11}; exp_w[1] = {1'b0, 32'h12}; exp_w[2] = {1'b1, 32'h13};
    got_q.delete(); done_cnt = 0; m_axis_tready = 1'b1;
    do_start(3, 2'b01);
    send(1'b1, 32'h99);
    send(1'b0, 32'h11); send(1'b1, 32'h21); send(1'b0, 32'h12);
    send(1'b1, 32'h22); send(1'b0, 32'h13); send(1'b1, 32'h23);
    cyc(6);
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL left_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      act = (i < got_q.size()) ? got_q[i] : 33'bx;
      total++; if (act !== exp_w[i]) begin bad++; $display("FAIL left_word%0d got=%h want=%h", i, act, exp_w[i]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL left_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_overflow();
    logic [32:0] act;
    got_q.delete(); done_cnt = 0; m_axis_tready = 1'b0;
    do_start(2, 2'b11);
    send(1'b1, 32'h5);
    send(1'b0, 32'hA1); send(1'b1, 32'hB1); send(1'b0, 32'hC1); send(1'b1, 32'hD1);
    total++; if (overflow_out !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow_out); end
    total++; if (drop_count_out !== 16'd2) begin bad++; $display("FAIL ovf_drops got=%0d want=2", drop_count_out); end
    total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL ovf_busy got=%b want=1", busy_out); end
    cyc(3);
    total++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {2'b10, 32'hA1}) begin bad++; $display("FAIL ovf_hold got=%b/%b/%h want=1/0/a1", m_axis_tvalid, m_axis_tlast, m_axis_tdata); end
    m_axis_tready = 1'b1;
    cyc(6);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL ovf_count got=%0d want=2", got_q.size()); end
    act = (got_q.size() > 0) ? got_q[0] : 33'bx;
    total++; if (act !== {1'b0, 32'hA1}) begin bad++; $display("FAIL ovf_word0 got=%h want=0a1", act); end
    act = (got_q.size() > 1) ? got_q[1] : 33'bx;
    total++; if (act !== {1'b1, 32'hB1}) begin bad++; $display("FAIL ovf_word1 got=%h want=1000000b1", act); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ovf_done got=%0d want=1", done_cnt); end
    total++; if (overflow_out !== 1'b1 || drop_count_out !== 16'd2) begin bad++; $display("FAIL ovf_persist got=%b/%0d want=1/2", overflow_out, drop_count_out); end
  endtask

  task automatic test_abort();
    logic [32:0] act;
    got_q.delete(); done_cnt = 0; m_axis_tready = 1'b0;
    do_start(2, 2'b11);
    total++; if (overflow_out !== 1'b0 || drop_count_out !== '0) begin bad++; $display("FAIL abort_clear got=%b/%0d want=0/0", overflow_out, drop_count_out); end
    send(1'b1, 32'h6); send(1'b0, 32'hA2); send(1'b1, 32'hB2);
    total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL abort_pre got=%b want=1", m_axis_tvalid); end
    abort_in = 1'b1; start_in = 1'b1; num_frames_in = 2; chan_sel_in = 2'b11;
    cyc();
    abort_in = 1'b0; start_in = 1'b0; num_frames_in = '0; chan_sel_in = 2'b00;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL abort_tvalid got=%b want=0", m_axis_tvalid); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy_out); end
    m_axis_tready = 1'b1;
    cyc(4);
    total++; if (got_q.size() != 0 || done_cnt != 0) begin bad++; $display("FAIL abort_quiet got=%0d words %0d done want=0/0", got_q.size(), done_cnt); end
    do_start(1, 2'b11);
    send(1'b1, 32'h7); send(1'b0, 32'hA3); send(1'b1, 32'hB3);
    cyc(5);
    act = (got_q.size() > 1) ? got_q[1] : 33'bx;
    total++; if (got_q.size() != 2 || got_q[0] !== {1'b0, 32'hA3} || act !== {1'b1, 32'hB3}) begin bad++; $display("FAIL abort_rerun got=%0d words last=%h want=2 words last=1000000b3", got_q.size(), act); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL abort_rerun_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_invalid_start();
    got_q.delete(); done_cnt = 0; m_axis_tready = 1'b1;
    do_start(0, 2'b11);
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL inv_zero_frames got=%b want=0", busy_out); end
    do_start(3, 2'b00);
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL inv_chan got=%b want=0", busy_out); end
    send(1'b1, 32'h8); send(1'b0, 32'h9); send(1'b1, 32'hA);
    cyc(3);
    total++; if (got_q.size() != 0 || done_cnt != 0) begin bad++; $display("FAIL inv_output got=%0d words %0d done want=0/0", got_q.size(), done_cnt); end
  endtask

  task automatic test_async_reset();
    m_axis_tready = 1'b0;
    do_start(2, 2'b11);
    send(1'b1, 32'h1); send(1'b0, 32'hA4); send(1'b1, 32'hB4); send(1'b0, 32'hC4);
    total++; if (overflow_out !== 1'b1 || drop_count_out !== 16'd1) begin bad++; $display("FAIL rst_pre got=%b/%0d want=1/1", overflow_out, drop_count_out); end
    #3 rst_in = 1'b1;
    #1;
    total++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0 || m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_async_m got=%b/%h/%b want=0/0/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
    total++; if (busy_out !== 1'b0 || done_out !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b/%b want=0/0", busy_out, done_out); end
    total++; if (overflow_out !== 1'b0 || drop_count_out !== '0) begin bad++; $display("FAIL rst_async_ovf got=%b/%0d want=0/0", overflow_out, drop_count_out); end
    cyc(2);
    rst_in = 1'b0;
    got_q.delete(); done_cnt = 0; m_axis_tready = 1'b1;
    send(1'b1, 32'h2); send(1'b0, 32'h3); send(1'b1, 32'h4);
    cyc(3);
    total++; if (got_q.size() != 0 || busy_out !== 1'b0) begin bad++; $display("FAIL rst_after got=%0d words busy=%b want=0/0", got_q.size(), busy_out); end
  endtask

  initial begin
    test_reset();
    test_stereo();
    test_left_only();
    test_overflow();
    test_abort();
    test_invalid_start();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mic_capture_controller.md
MIC_CAPTURE_CONTROLLER -- requirements
Module: mic_capture_controller

Interface
REQ-001 SHALL have parameter FRAMES_W, default 16, width of the stereo-frame count.
REQ-002 SHALL have parameter DROP_W, default 16, width of the dropped-word counter.
REQ-003 clk_in  input  1  single system clock; all state on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous and active-high.
REQ-005 start_in  input  1  one-cycle capture request.
REQ-006 abort_in  input  1  one-cycle cancel request.
REQ-007 num_frames_in  input  FRAMES_W  stereo frames per capture; sampled only on start acceptance.
REQ-008 chan_sel_in  input  2  01 left only, 10 right only, 11 both, 00 invalid; sampled only on start acceptance.
REQ-009 s_axis_tvalid / s_axis_tdata[31:0] / s_axis_tlast  input  word stream from i2s_receiver; tlast=1 marks the right-channel word.
REQ-010 s_axis_tready  output  1  constant 1; the audio source never stalls.
REQ-011 m_axis_tvalid / m_axis_tdata[31:0] / m_axis_tlast  output  captured stream; m_axis_tready input 1.
REQ-012 busy_out  output  1  high in any state other than IDLE.
REQ-013 done_out  output  1  one-cycle pulse on normal completion.
REQ-014 overflow_out  output  1  sticky flag set when a word is dropped.
REQ-015 drop_count_out  output  DROP_W  saturating count of dropped words.

Function
REQ-016 States SHALL be IDLE, ALIGN, CAPTURE and DRAIN.
REQ-017 IDLE: start_in with num_frames_in!=0 and chan_sel_in!=00 -> latch both, clear overflow_out and drop_count_out, go to ALIGN.
REQ-018 start_in under any other condition, or in any non-IDLE state, SHALL be ignored.
REQ-019 Input words in IDLE SHALL be discarded.
REQ-020 ALIGN: input words SHALL be discarded until a word with tlast=1 is accepted; go to CAPTURE on the next cycle, so the first captured word is a left word.
REQ-021 CAPTURE: each input word is left (tlast=0) or right (tlast=1); a word SHALL be selected if its channel is enabled by the latched chan_sel.
REQ-022 CAPTURE: the frame counter SHALL decrement on each right word.
REQ-023 The last selected word of the final frame SHALL carry m_axis_tlast=1; all other words 0.
REQ-024 CAPTURE: the right word of the final frame SHALL cause a transition to DRAIN.
REQ-025 DRAIN: when the buffer is empty, go to IDLE and assert done_out for exactly one cycle.
REQ-026 Selected words SHALL enter a 2-entry FIFO of {tdata, tlast}.
REQ-027 Push SHALL succeed when not full, or when full with a pop in the same cycle.
REQ-028 A selected word that cannot be pushed SHALL be dropped: overflow_out<=1, drop_count_out increments, saturating at all-ones.
REQ-029 If the dropped word is the final word, the youngest buffered entry SHALL have its tlast forced to 1, so every capture terminates with tlast.
REQ-030 Latency: a selected word pushed into an empty FIFO SHALL appear on m_axis_tvalid the following cycle.
REQ-031 m_axis_tdata and m_axis_tlast SHALL be held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-032 abort_in in any non-IDLE state SHALL flush the FIFO and go to IDLE with no done_out pulse; m_axis_tvalid is 0 the next cycle.
REQ-033 abort_in SHALL take priority over start_in and over every other transition in the same cycle.
REQ-034 overflow_out and drop_count_out SHALL persist after done or abort until reset or the next accepted start.

Reset
REQ-035 rst_in SHALL immediately, without waiting for a clock edge, force state IDLE, FIFO empty, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy_out=0, done_out=0, overflow_out=0, drop_count_out=0, and all latched configuration to 0.
REQ-036 Reset asserted mid-capture SHALL discard buffered words; after release the block SHALL wait in IDLE for a new start_in.

Verification
REQ-037 Scenario: chan_sel=11, num_frames=2, tready=1; input stray R, then L=0xA, R=0xB, L=0xC, R=0xD -> output A,B,C,D, tlast only on D, done_out pulses once after D is accepted.
REQ-038 Scenario: chan_sel=01, num_frames=3, tready=1 -> exactly three left words output, tlast on the third, no right words.
REQ-039 Scenario: chan_sel=11, num_frames=2, tready=0 throughout capture -> A and B buffered, C and D dropped, overflow_out=1, drop_count_out=2; on tready=1, B has tlast=1, then done_out.
REQ-040 Scenario: abort_in after the second captured word -> m_axis_tvalid=0 next cycle, busy_out=0, no done_out; a subsequent start runs normally.
REQ-041 Scenario: start_in with num_frames_in=0 or chan_sel_in=00 -> busy_out stays 0 and no output is produced.
REQ-042 Scenario: rst_in asserted mid-CAPTURE between clock edges -> all outputs at reset values before the next rising clock edge.
